// File: rtl/ddr_cmd_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr_cmd_responder_pkg - shared command/address/error types and timing (rev 1.0)
// ---------------------------------------------------------------------------
package ddr_cmd_responder_pkg;

  localparam int DEF_TRCD  = 39;
  localparam int DEF_TRP   = 39;
  localparam int DEF_TRFC  = 295;
  localparam int DEF_TCL   = 40;
  localparam int DEF_BURST = 8;

  localparam int NUM_BANKS  = 32;
  localparam int BANK_IDX_W = 5;
  localparam int ROW_W      = 16;
  localparam int TIMER_W    = 16;

  typedef enum logic [2:0] {
    ACT0 = 3'd0,
    ACT1 = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    WR0  = 3'd4,
    WR1  = 3'd5,
    PRE  = 3'd6,
    REF  = 3'd7
  } commands;

  typedef struct packed {
    logic [2:0]       rank;
    logic [2:0]       bank_group;
    logic [1:0]       bank;
    logic [ROW_W-1:0] row;
    logic [9:0]       column;
  } add_map;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_SEQ         = 3'd1,
    ERR_TRFC        = 3'd2,
    ERR_BANK_OPEN   = 3'd3,
    ERR_BANK_CLOSED = 3'd4,
    ERR_TRP         = 3'd5,
    ERR_TRCD        = 3'd6,
    ERR_RD_BUSY     = 3'd7
  } err_t;

  function automatic logic [BANK_IDX_W-1:0] bank_index(input add_map a);
    return {a.bank_group, a.bank};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_cmd_responder_bank_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr_bank_table - per-bank open flag, open row and countdown timer (rev 1.0)
// ---------------------------------------------------------------------------
module ddr_bank_table
  import ddr_cmd_responder_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  upd_en,
  input  logic                  upd_open,
  input  logic [BANK_IDX_W-1:0] upd_idx,
  input  logic [ROW_W-1:0]      upd_row,
  input  logic [TIMER_W-1:0]    upd_timer,
  input  logic [BANK_IDX_W-1:0] rd_idx,
  output logic [ROW_W-1:0]      rd_row,
  output logic [NUM_BANKS-1:0]  open_flags,
  output logic [NUM_BANKS-1:0]  busy
);

  logic [ROW_W-1:0] rows [NUM_BANKS];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic               hit;
    logic               open_q;
    logic [TIMER_W-1:0] timer;

    assign hit = upd_en && (upd_idx == BANK_IDX_W'(i));

    // A fresh load wins over the running countdown, which stops at zero.
    always_ff @(posedge clock) begin
      if (reset) begin
        open_q <= 1'b0;
        timer  <= '0;
      end else if (hit) begin
        open_q <= upd_open;
        timer  <= upd_timer;
      end else if (timer != '0) begin
        timer  <= timer - 1'b1;
      end
    end

    assign open_flags[i] = open_q;
    assign busy[i]       = (timer != '0);
  end

  always_ff @(posedge clock) begin
    if (upd_en && upd_open) rows[upd_idx] <= upd_row;
  end

  assign rd_row = rows[rd_idx];

endmodule
`default_nettype wire

// File: rtl/ddr_cmd_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr_cmd_responder - DDR command legality checker and read-window generator (rev 1.0)
// ---------------------------------------------------------------------------
module ddr_cmd_responder
  import ddr_cmd_responder_pkg::*;
#(
  parameter int TRCD  = DEF_TRCD,
  parameter int TRP   = DEF_TRP,
  parameter int TRFC  = DEF_TRFC,
  parameter int TCL   = DEF_TCL,
  parameter int BURST = DEF_BURST
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  commands              cmd,
  input  add_map               addr,
  output logic                 cmd_accept,
  output commands              accepted_cmd,
  output logic                 err_valid,
  output err_t                 err_code,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic                 rd_data_valid
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0]            state, state_nxt;
  commands               pend_cmd;
  logic [BANK_IDX_W-1:0] pend_idx;
  logic [ROW_W-1:0]      pend_row;
  logic [TIMER_W-1:0]    ref_timer, rd_cnt;
  logic [NUM_BANKS-1:0]  bank_busy;
  logic [BANK_IDX_W-1:0] addr_idx, tbl_idx;
  logic [ROW_W-1:0]      stored_row;
  logic                  is_phase0, is_phase1, phase1_match, is_rdwr0;
  err_t                  chk_err;

  logic                  commit, reject, capture, tbl_we, tbl_open, ref_load, rd_load;
  commands               commit_cmd;
  err_t                  reject_code;
  logic [TIMER_W-1:0]    tbl_timer;
  logic                  unused_bits;

  assign addr_idx     = bank_index(addr);
  assign is_phase0    = cmd inside {ACT0, RD0, WR0};
  assign is_phase1    = cmd inside {ACT1, RD1, WR1};
  assign is_rdwr0     = (cmd == RD0) || (cmd == WR0);
  assign phase1_match = cmd_valid && (cmd == commands'(pend_cmd + 3'd1));
  assign tbl_idx      = (state == ST_PEND) ? pend_idx : addr_idx;
  assign unused_bits  = ^{addr.rank, addr.column, stored_row};

  // Legality of a phase-0 or single-phase command, highest priority first.
  always_comb begin
    chk_err = ERR_NONE;
    if (ref_timer != '0)
      chk_err = ERR_TRFC;
    else if ((cmd == ACT0 && bank_open[addr_idx]) || (cmd == REF && |bank_open))
      chk_err = ERR_BANK_OPEN;
    else if (is_rdwr0 && !bank_open[addr_idx])
      chk_err = ERR_BANK_CLOSED;
    else if (cmd == ACT0 && bank_busy[addr_idx])
      chk_err = ERR_TRP;
    else if (is_rdwr0 && bank_busy[addr_idx])
      chk_err = ERR_TRCD;
    else if (cmd == RD0 && rd_cnt != '0)
      chk_err = ERR_RD_BUSY;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    if (state == ST_IDLE && cmd_valid && is_phase0 && chk_err == ERR_NONE)
      state_nxt = ST_PEND;
  end

  always_comb begin
    commit      = 1'b0;
    commit_cmd  = ACT0;
    reject      = 1'b0;
    reject_code = ERR_NONE;
    capture     = 1'b0;
    tbl_we      = 1'b0;
    tbl_open    = 1'b0;
    tbl_timer   = '0;
    ref_load    = 1'b0;
    rd_load     = 1'b0;
    if (state == ST_PEND) begin
      if (phase1_match) begin
        commit     = 1'b1;
        commit_cmd = cmd;
        if (cmd == ACT1) begin
          tbl_we    = 1'b1;
          tbl_open  = 1'b1;
          tbl_timer = TIMER_W'(TRCD - 1);
        end
        rd_load = (cmd == RD1);
      end else begin
        reject      = 1'b1;
        reject_code = ERR_SEQ;
      end
    end else if (cmd_valid) begin
      if (is_phase1) begin
        reject      = 1'b1;
        reject_code = ERR_SEQ;
      end else if (chk_err != ERR_NONE) begin
        reject      = 1'b1;
        reject_code = chk_err;
      end else if (cmd == PRE) begin
        commit     = 1'b1;
        commit_cmd = PRE;
        tbl_we     = 1'b1;
        tbl_timer  = TIMER_W'(TRP - 1);
      end else if (cmd == REF) begin
        commit     = 1'b1;
        commit_cmd = REF;
        ref_load   = 1'b1;
      end else begin
        capture = 1'b1;
      end
    end
  end

  // Timers hold "cycles still to wait", so zero means the constraint is met.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_cmd     <= ACT0;
      pend_idx     <= '0;
      pend_row     <= '0;
      ref_timer    <= '0;
      rd_cnt       <= '0;
      cmd_accept   <= 1'b0;
      accepted_cmd <= ACT0;
      err_valid    <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      if (capture) begin
        pend_cmd <= cmd;
        pend_idx <= addr_idx;
        pend_row <= addr.row;
      end
      if (ref_load)              ref_timer <= TIMER_W'(TRFC - 1);
      else if (ref_timer != '0)  ref_timer <= ref_timer - 1'b1;
      if (rd_load)               rd_cnt <= TIMER_W'(TCL + BURST - 1);
      else if (rd_cnt != '0)     rd_cnt <= rd_cnt - 1'b1;
      cmd_accept   <= commit;
      accepted_cmd <= commit_cmd;
      err_valid    <= reject;
      err_code     <= reject_code;
    end
  end

  assign rd_data_valid = (rd_cnt != '0) && (rd_cnt <= TIMER_W'(BURST));

  ddr_bank_table u_bank_table (
    .clock      (clock),
    .reset      (reset),
    .upd_en     (tbl_we),
    .upd_open   (tbl_open),
    .upd_idx    (tbl_idx),
    .upd_row    (pend_row),
    .upd_timer  (tbl_timer),
    .rd_idx     (tbl_idx),
    .rd_row     (stored_row),
    .open_flags (bank_open),
    .busy       (bank_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_ddr_cmd_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ddr_cmd_responder - directed and random bench with a time-stamp reference model (rev 1.0)
// ---------------------------------------------------------------------------
module tb_ddr_cmd_responder;
  import ddr_cmd_responder_pkg::*;

  localparam int     TRCD  = 39;
  localparam int     TRP   = 39;
  localparam int     TRFC  = 295;
  localparam int     TCL   = 40;
  localparam int     BURST = 8;
  localparam longint FAR   = -1000000;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 cmd_valid = 1'b0;
  commands              cmd = ACT0;
  add_map               addr = '0;
  logic                 cmd_accept;
  commands              accepted_cmd;
  logic                 err_valid;
  err_t                 err_code;
  logic [NUM_BANKS-1:0] bank_open;
  logic                 rd_data_valid;

  ddr_cmd_responder #(
    .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .TCL(TCL), .BURST(BURST)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .addr(addr),
    .cmd_accept(cmd_accept), .accepted_cmd(accepted_cmd), .err_valid(err_valid),
    .err_code(err_code), .bank_open(bank_open), .rd_data_valid(rd_data_valid)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: remembers when each event happened and judges by elapsed cycles.
  longint  n = 0;
  bit      m_open [NUM_BANKS];
  longint  m_act  [NUM_BANKS];
  longint  m_pre  [NUM_BANKS];
  longint  m_ref, m_rd;
  bit      m_pend;
  commands m_pcmd;
  int      m_pidx;
  bit      e_acc, e_errv, e_rdv;
  commands e_acmd;
  err_t    e_errc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic commands phase1_of(input commands c);
    case (c)
      ACT0:    return ACT1;
      RD0:     return RD1;
      default: return WR1;
    endcase
  endfunction

  task automatic model(input bit rst, input bit v, input commands c, input add_map a);
    int   idx;
    err_t e;
    bit   any_open;
    idx = int'({a.bank_group, a.bank});
    e_acc = 0; e_acmd = ACT0; e_errv = 0; e_errc = ERR_NONE;
    any_open = 0;
    foreach (m_open[i]) any_open |= m_open[i];
    if (rst) begin
      m_pend = 0; m_ref = FAR; m_rd = FAR;
      foreach (m_open[i]) begin m_open[i] = 0; m_act[i] = FAR; m_pre[i] = FAR; end
    end else if (m_pend) begin
      m_pend = 0;
      if (v && c == phase1_of(m_pcmd)) begin
        e_acc = 1; e_acmd = c;
        if (c == ACT1) begin m_open[m_pidx] = 1; m_act[m_pidx] = n; end
        if (c == RD1) m_rd = n;
      end else begin
        e_errv = 1; e_errc = ERR_SEQ;
      end
    end else if (v) begin
      if (c == ACT1 || c == RD1 || c == WR1) begin
        e_errv = 1; e_errc = ERR_SEQ;
      end else begin
        e = ERR_NONE;
        if (n - m_ref < TRFC)                                     e = ERR_TRFC;
        else if ((c == ACT0 && m_open[idx]) || (c == REF && any_open)) e = ERR_BANK_OPEN;
        else if ((c == RD0 || c == WR0) && !m_open[idx])          e = ERR_BANK_CLOSED;
        else if (c == ACT0 && n - m_pre[idx] < TRP)               e = ERR_TRP;
        else if ((c == RD0 || c == WR0) && n - m_act[idx] < TRCD) e = ERR_TRCD;
        else if (c == RD0 && n - m_rd < TCL + BURST)              e = ERR_RD_BUSY;
        if (e != ERR_NONE) begin
          e_errv = 1; e_errc = e;
        end else if (c == PRE) begin
          m_open[idx] = 0; m_pre[idx] = n; e_acc = 1; e_acmd = PRE;
        end else if (c == REF) begin
          m_ref = n; e_acc = 1; e_acmd = REF;
        end else begin
          m_pend = 1; m_pcmd = c; m_pidx = idx;
        end
      end
    end
    n++;
    e_rdv = (n - m_rd >= TCL) && (n - m_rd < TCL + BURST);
  endtask

  task automatic cyc(input bit rst, input bit v, input commands c, input add_map a);
    logic [NUM_BANKS-1:0] exp_open;
    @(negedge clock);
    reset = rst; cmd_valid = v; cmd = c; addr = a;
    @(posedge clock);
    model(rst, v, c, a);
    #1;
    foreach (m_open[i]) exp_open[i] = m_open[i];
    check("cmd_accept",    cmd_accept,    e_acc);
    check("accepted_cmd",  accepted_cmd,  e_acmd);
    check("err_valid",     err_valid,     e_errv);
    check("err_code",      err_code,      e_errc);
    check("bank_open",     bank_open,     exp_open);
    check("rd_data_valid", rd_data_valid, e_rdv);
  endtask

  function automatic add_map rnd_addr();
    add_map a;
    a = add_map'(34'({$urandom(), $urandom()}));
    return a;
  endfunction

  function automatic add_map mk(input int idx, input int row);
    add_map a;
    a = rnd_addr();
    a.bank_group = 3'(idx >> 2);
    a.bank       = 2'(idx & 3);
    a.row        = 16'(row);
    return a;
  endfunction

  task automatic send(input commands c, input add_map a);
    cyc(1'b0, 1'b1, c, a);
  endtask

  task automatic nop(input int k);
    for (int i = 0; i < k; i++)
      cyc(1'b0, 1'b0, commands'(3'($urandom_range(0, 7))), rnd_addr());
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, ACT0, '0);
  endtask

  initial begin
    add_map b9;
    int     first, cnt;
    bit     seen;
    b9 = mk(9, 'h1234);

    do_reset(); do_reset();
    check("rst_cmd_accept",   cmd_accept,    0);
    check("rst_accepted_cmd", accepted_cmd,  ACT0);
    check("rst_err_code",     err_code,      ERR_NONE);
    check("rst_bank_open",    bank_open,     0);

    // Activate then read exactly at the tRCD boundary.
    send(ACT0, b9); send(ACT1, rnd_addr());
    check("act1_accepted", accepted_cmd, ACT1);
    nop(38); send(RD0, b9); send(RD1, rnd_addr());
    check("rd1_accept",   cmd_accept,   1);
    check("rd1_accepted", accepted_cmd, RD1);
    check("bank9_open",   bank_open[9], 1);
    first = -1; cnt = 0;
    for (int j = 2; j <= 52; j++) begin
      nop(1);
      if (rd_data_valid) begin
        if (first < 0) first = j;
        cnt++;
      end
    end
    check("rdv_first_offset", first, TCL);
    check("rdv_length",       cnt,   BURST);

    // Read one cycle too early.
    do_reset();
    send(ACT0, b9); send(ACT1, rnd_addr());
    nop(37); send(RD0, b9);
    check("trcd_err_valid", err_valid, 1);
    check("trcd_err_code",  err_code,  ERR_TRCD);
    send(RD1, rnd_addr());
    seen = 0;
    for (int j = 0; j < 60; j++) begin nop(1); seen |= rd_data_valid; end
    check("trcd_no_rdv", seen, 0);

    // ACT0 broken by a NOP.
    send(ACT0, mk(6, 5)); nop(1);
    check("seq_err_code",  err_code,  ERR_SEQ);
    check("seq_bank_open", bank_open, 32'h0000_0200);

    // Refresh rules.
    send(REF, rnd_addr());
    check("ref_open_err", err_code, ERR_BANK_OPEN);
    send(PRE, b9);
    check("pre_accepted", accepted_cmd, PRE);
    send(REF, rnd_addr());
    check("ref_accepted", accepted_cmd, REF);
    nop(293); send(ACT0, b9);
    check("trfc_err", err_code, ERR_TRFC);
    send(ACT0, b9);
    check("trfc_ok_no_err", err_valid, 0);
    send(ACT1, rnd_addr());
    check("trfc_act1", accepted_cmd, ACT1);

    // Precharge to activate boundary.
    send(PRE, b9); nop(37); send(ACT0, b9);
    check("trp_err", err_code, ERR_TRP);
    send(ACT0, b9);
    check("trp_ok_no_err", err_valid, 0);
    send(ACT1, rnd_addr());
    check("trp_act1", cmd_accept, 1);

    // Second read during a burst, then reset mid-burst.
    nop(38); send(RD0, b9); send(RD1, rnd_addr());
    nop(39);
    check("burst_active", rd_data_valid, 1);
    send(RD0, b9);
    check("rd_busy_err", err_code, ERR_RD_BUSY);
    send(RD1, rnd_addr());
    do_reset();
    check("rst_mid_burst_rdv",  rd_data_valid, 0);
    check("rst_mid_burst_open", bank_open,     0);
    nop(10);

    // Random traffic on a few banks, judged by the model each cycle.
    for (int it = 0; it < 350; it++) begin
      int     r, idx;
      add_map a;
      idx = (it % 5 == 0) ? $urandom_range(0, 31) : (($urandom_range(0, 1) == 0) ? 9 : 17);
      a   = mk(idx, $urandom_range(0, 65535));
      r   = $urandom_range(0, 99);
      if      (r < 25) begin send(ACT0, a); send(ACT1, rnd_addr()); end
      else if (r < 45) begin send(RD0, a);  send(RD1, rnd_addr()); end
      else if (r < 55) begin send(WR0, a);  send(WR1, rnd_addr()); end
      else if (r < 75) send(PRE, a);
      else if (r < 78) send(REF, a);
      else if (r < 88) begin
        send(commands'(3'(2 * $urandom_range(0, 2))), a);
        cyc(1'b0, 1'($urandom_range(0, 1)), commands'(3'($urandom_range(0, 7))), rnd_addr());
      end
      else if (r < 93) send(commands'(3'(2 * $urandom_range(0, 2) + 1)), a);
      else if (r < 96) do_reset();
      else nop(1);
      nop($urandom_range(0, 45));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_cmd_responder.md
DDR_CMD_RESPONDER -- requirements
Module: ddr_cmd_responder

Interface
REQ-001 The block SHALL have parameters TRCD 39, minimum cycles from the ACT1 cycle to a RD0/WR0 cycle on the same bank.
REQ-002 The block SHALL have parameter TRP 39, minimum cycles from a PRE cycle to an ACT0 cycle on the same bank.
REQ-003 The block SHALL have parameter TRFC 295, minimum cycles from a REF cycle to any next command.
REQ-004 The block SHALL have parameter TCL 40, cycles from the RD1 cycle to the first rd_data_valid cycle.
REQ-005 The block SHALL have parameter BURST 8, the number of rd_data_valid cycles per read.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset.
REQ-007 Port clock, input, 1: sole clock, rising edge.
REQ-008 Port reset, input, 1: synchronous active-high reset.
REQ-009 Port cmd_valid, input, 1: the cmd and addr ports carry a command this cycle.
REQ-010 Port cmd, input, commands (3): ACT0/ACT1/RD0/RD1/WR0/WR1/PRE/REF.
REQ-011 Port addr, input, add_map (34): mapped address; only bank_group, bank and row are used.
REQ-012 Port cmd_accept, output, 1: a command committed in the previous cycle.
REQ-013 Port accepted_cmd, output, commands: the committed command (ACT1/RD1/WR1/PRE/REF); otherwise 0.
REQ-014 Port err_valid, output, 1: a one-cycle pulse flagging a rejected command.
REQ-015 Port err_code, output, err_t (3): the reason for rejection; ERR_NONE when err_valid is low.
REQ-016 Port bank_open, output, 32: open flag per bank, index {bank_group,bank}.
REQ-017 Port rd_data_valid, output, 1: the read burst window.

Function
REQ-018 ACT, RD and WR SHALL be two-phase commands: phase-0 in cycle n and the matching phase-1 with cmd_valid in cycle n+1; all address fields SHALL be sampled in the phase-0 cycle.
REQ-019 PRE and REF SHALL be single-phase commands, committing in their own cycle.
REQ-020 Any of the following SHALL give ERR_SEQ and discard both cycles: phase-0 followed by anything other than its matching phase-1, phase-1 with no pending phase-0, or PRE/REF while a phase-0 is pending.
REQ-021 ACT commit SHALL set the bank open, store the row and load the bank timer for TRCD.
REQ-022 PRE commit SHALL clear the open flag and load the bank timer for TRP; PRE to a closed bank SHALL be legal.
REQ-023 REF SHALL load the global timer for TRFC.
REQ-024 Checks SHALL apply at the phase-0 or single-phase cycle, in this priority order:
- ERR_TRFC: the global timer is running.
- ERR_BANK_OPEN: ACT0 to an open bank, or REF while any bank is open.
- ERR_BANK_CLOSED: RD0/WR0 to a closed bank.
- ERR_TRP: ACT0 while the bank timer is running.
- ERR_TRCD: RD0/WR0 while the bank timer is running.
- ERR_RD_BUSY: RD0 while a read is in latency or burst.
REQ-025 RD/WR address row SHALL be ignored; the stored open row is authoritative.
REQ-026 A rejected command SHALL leave all state unchanged.
REQ-027 err_valid and err_code SHALL be registered and appear the cycle after the offending cycle; for ERR_SEQ this is the cycle after the phase-1 or non-matching cycle.
REQ-028 cmd_accept and accepted_cmd SHALL be registered and appear the cycle after the commit cycle.
REQ-029 rd_data_valid SHALL be high for cycles RD1+TCL through RD1+TCL+BURST-1.
REQ-030 Timers SHALL saturate at zero; an elapsed count exactly equal to the parameter SHALL be legal.
REQ-031 cmd_valid low SHALL be a NOP, except that it breaks a pending two-phase command (ERR_SEQ).

Reset
REQ-032 Reset SHALL clear all of the following:
- cmd_accept, err_valid and rd_data_valid to 0;
- accepted_cmd to ACT0;
- err_code to ERR_NONE;
- bank_open to 0;
- all timers, the pending phase-0 and any in-flight read.
REQ-033 Reset asserted mid-burst SHALL drive rd_data_valid low the following cycle with no resumption.

Structure
REQ-034 The err_t enum and the default timing constants SHALL be added to the shared package, alongside commands and add_map.
REQ-035 Per-bank state (open flag, row and timer, 32 entries) SHALL be a sub-module, ddr_bank_table.

Verification
REQ-036 The bench SHALL check: ACT0/ACT1 to BG2/B1 row 0x1234, then RD0/RD1 39 cycles after ACT1 -> cmd_accept with RD1; rd_data_valid high from RD1+40 for 8 cycles; bank_open[9]=1.
REQ-037 The bench SHALL check: same sequence with RD0 38 cycles after ACT1 -> err_code ERR_TRCD; no rd_data_valid.
REQ-038 The bench SHALL check: ACT0 followed by a NOP -> ERR_SEQ; bank_open unchanged.
REQ-039 The bench SHALL check: REF with bank 9 open -> ERR_BANK_OPEN; then PRE, REF and ACT0 at REF+294 -> ERR_TRFC, and at REF+295 -> accepted.
REQ-040 The bench SHALL check: PRE then ACT0 at PRE+38 -> ERR_TRP, and at PRE+39 -> accepted.
REQ-041 The bench SHALL check: a second RD0 during a burst -> ERR_RD_BUSY; reset mid-burst -> rd_data_valid 0 next cycle and bank_open 0.
